// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: segment bit order,
// digit patterns and the readback FSM state type.
package seg7_pkg;

  // Position of each segment on the 7-bit bus {a,b,c,d,e,f,g}
  localparam int SEG_BIT_A = 6;
  localparam int SEG_BIT_B = 5;
  localparam int SEG_BIT_C = 4;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 2;
  localparam int SEG_BIT_F = 1;
  localparam int SEG_BIT_G = 0;

  // Places individual segment states at their bus positions
  function automatic logic [6:0] seg_of(input logic a, input logic b, input logic c,
                                        input logic d, input logic e, input logic f,
                                        input logic g);
    logic [6:0] p;
    p = '0;
    p[SEG_BIT_A] = a;
    p[SEG_BIT_B] = b;
    p[SEG_BIT_C] = c;
    p[SEG_BIT_D] = d;
    p[SEG_BIT_E] = e;
    p[SEG_BIT_F] = f;
    p[SEG_BIT_G] = g;
    return p;
  endfunction

  localparam logic [6:0] SEG_0 = seg_of(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // 7E
  localparam logic [6:0] SEG_1 = seg_of(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // 30
  localparam logic [6:0] SEG_2 = seg_of(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); // 6D
  localparam logic [6:0] SEG_3 = seg_of(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // 79
  localparam logic [6:0] SEG_4 = seg_of(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); // 33
  localparam logic [6:0] SEG_5 = seg_of(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // 5B
  localparam logic [6:0] SEG_6 = seg_of(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); // 5F
  localparam logic [6:0] SEG_7 = seg_of(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // 70
  localparam logic [6:0] SEG_8 = seg_of(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); // 7F
  localparam logic [6:0] SEG_9 = seg_of(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // 7B
  localparam logic [6:0] SEG_A = seg_of(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); // 77
  localparam logic [6:0] SEG_B = seg_of(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); // 1F
  localparam logic [6:0] SEG_C = seg_of(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // 4E
  localparam logic [6:0] SEG_D = seg_of(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); // 3D
  localparam logic [6:0] SEG_E = seg_of(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); // 4F
  localparam logic [6:0] SEG_F = seg_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); // 47

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_a_nibble.sv
// Combinational segment pattern -> {valid, nibble} lookup.
// Define SEG_HEX_EN to also accept the A..F letter patterns.
module seg7_a_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table lookup; anything outside the table (blank included) is rejected
  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
`ifdef SEG_HEX_EN
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
`else
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/codificador_7seg_bcd.sv
// Multiplexed common-cathode 7-segment readback: synchronizes the display
// bus, waits for each digit strobe to settle, decodes it and latches the
// nibble. frame_done pulses once every digit has been captured.
// Optional macro SEG_HEX_EN (in seg7_a_nibble) enables A..F decoding.
module codificador_7seg_bcd
  import seg7_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         seg,
  input  logic [N_DIG-1:0]   dig_en,
  output logic [4*N_DIG-1:0] bcd,
  output logic [N_DIG-1:0]   dig_valid,
  output logic               pat_err,
  output logic               frame_done
);

  localparam int SW = N_DIG + 7;
  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
  localparam logic [SW-1:0] SYNC_RST = {{N_DIG{1'b1}}, 7'h00};

  logic [SW-1:0]    sync_p0, sync_p1, prev_p2;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_nxt;
  logic [N_DIG-1:0] s_dig;
  logic [6:0]       s_seg;
  logic             sel_ok, changed, capture, cap_ok;
  logic             pat_ok;
  logic [3:0]       pat_nib;
  logic [N_DIG-1:0] valid_base, valid_set;

  // True when exactly one digit select is driven low
  function automatic logic one_low(input logic [N_DIG-1:0] en);
    logic [N_DIG-1:0] x;
    x = ~en;
    return (x != '0) && ((x & (x - N_DIG'(1))) == '0);
  endfunction

  assign {s_dig, s_seg} = sync_p1;
  assign changed        = (sync_p1 != prev_p2);
  assign sel_ok         = one_low(s_dig);
  assign cap_ok         = capture && pat_ok;
  assign valid_base     = frame_done ? '0 : dig_valid;
  assign valid_set      = valid_base | ~s_dig;

  seg7_a_nibble u_lut (
    .seg    (s_seg),
    .valid  (pat_ok),
    .nibble (pat_nib)
  );

  // p0/p1: two-flop synchronizer; p2: previous synchronized sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= SYNC_RST;
      sync_p1 <= SYNC_RST;
      prev_p2 <= SYNC_RST;
    end else begin
      sync_p0 <= {dig_en, seg};
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // Stability counter: restarts on any change or bad select, saturates at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (changed || !sel_ok) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_nxt;
  end

  // Next state and capture strobe; capture also needs the current sample unchanged
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      SCAN:    if (sel_ok) state_nxt = SETTLE;
      SETTLE: begin
        if (!sel_ok) begin
          state_nxt = SCAN;
        end else if (!changed && cnt == CNT_MAX) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD:    if (changed) state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // Capture outputs: latch nibble, track captured digits, raise one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd        <= '0;
      dig_valid  <= '0;
      pat_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pat_err    <= capture && !pat_ok;
      frame_done <= cap_ok && (valid_set == '1);
      dig_valid  <= cap_ok ? valid_set : valid_base;
      if (cap_ok) begin
        for (int i = 0; i < N_DIG; i++) begin
          if (!s_dig[i]) bcd[4*i +: 4] <= pat_nib;
        end
      end
    end
  end

endmodule

// File: doc/codificador_7seg_bcd.md
# codificador_7seg_bcd

- Reads back a multiplexed common-cathode 7-segment display bus and recovers the BCD digits being shown.
- It is the receiving end of the binary-to-7-segment decoder path: it sits on the FPGA between the display driver outputs (or an external display harness) and self-check or readback logic.
- Each digit strobe is synchronized, debounced until stable, decoded to a nibble and latched. A pulse is raised when a complete frame of digits has been captured.

## Interface
- `N_DIG`, 4: number of multiplexed digits, range 1..8.
- `STABLE_CYC`, 8: consecutive identical synchronized samples required before capture, minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `seg` in 7: segment lines `{a,b,c,d,e,f,g}`, active-high (common cathode).
- `dig_en` in `N_DIG`: digit selects, active-low, one-hot-low when valid.
- `bcd` out `4*N_DIG`: captured nibbles; digit i occupies bits `[4i+3:4i]`.
- `dig_valid` out `N_DIG`: digit i captured since the last frame.
- `pat_err` out 1: one-cycle pulse when a settled pattern is not decodable.
- `frame_done` out 1: one-cycle pulse when all `N_DIG` digits have been captured.

## Operation
- Inputs pass through a 2-FF synchronizer; all logic below sees the synchronized `{dig_en,seg}` sample `s`.
- Stability counter `cnt`:
  - Clears to 0 when `s` differs from the previous sample or `dig_en` is not exactly one bit low.
  - Otherwise increments, saturating at `STABLE_CYC-1`.
- FSM:
  - SCAN: wait until `dig_en` is one-hot-low, then go to SETTLE.
  - SETTLE: if `s` changes, restart the count (stay in SETTLE, `cnt`=0). If `dig_en` becomes invalid, go to SCAN. When `cnt==STABLE_CYC-1`, capture and go to HOLD.
  - HOLD: stay until `s` changes, then go to SCAN. The same strobe is never captured twice.
- Capture:
  - Valid pattern: decode, write to the selected digit's nibble, set its `dig_valid` bit.
  - Invalid pattern: leave the nibble unchanged, pulse `pat_err`, leave `dig_valid` unchanged.
- Decode table (`seg` hex → value): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9. All other patterns are invalid, including 00 (blank).
- Frame completion:
  - When a capture makes `dig_valid` all ones, `frame_done` pulses on that same edge.
  - `dig_valid` clears to 0 on the next edge.
  - `bcd` holds its value.
- A capture on a digit whose `dig_valid` bit is already set overwrites the nibble. It is not an error.

## Timing
- Reset values:
  - `bcd`=0, `dig_valid`=0, `pat_err`=0, `frame_done`=0.
  - FSM in SCAN, `cnt`=0, synchronizer flops at all-ones for `dig_en` and 0 for `seg`.
- Latency: `bcd` updates `STABLE_CYC+3` rising edges after the pins settle, counted from the first edge that samples the new value.
- `pat_err` and `frame_done` are single-cycle pulses, registered, and never held.
- A pin glitch shorter than `STABLE_CYC` cycles causes no capture.
- Reset mid-SETTLE: everything returns to reset values immediately. Capture requires a fresh full settle after release.
- Wrap-around: `cnt` saturates and never wraps. Its width is `$clog2(STABLE_CYC)`.

## Configuration
- `SEG_HEX_EN` defined:
  - Also decode 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F.
  - Nibble values A..F are legal in `bcd`.
- Not defined: those six patterns are invalid and pulse `pat_err`.

## Structure
- Shared package `seg7_pkg`:
  - Segment pattern constants (`SEG_0`..`SEG_9`, `SEG_A`..`SEG_F`).
  - FSM state typedef (SCAN, SETTLE, HOLD).
  - Segment bit-order definition, shared with the existing decoder.
- Sub-module `seg7_a_nibble`: purely combinational pattern→{valid, nibble} lookup, honoring `SEG_HEX_EN`, instanced once.

## Test plan
- Reset, then hold `dig_en`=1110, `seg`=6D for 12 cycles → on edge 11 `bcd[3:0]`=2, `dig_valid`=0001; no `pat_err`.
- Scan digits 0..3 with 79, 5B, 7B, 7E, each held for 12 cycles → `bcd`=16'h0953, one `frame_done` pulse, `dig_valid` back to 0 on the following edge.
- `seg` toggles every 5 cycles with `STABLE_CYC`=8 → no capture, `bcd` unchanged, no pulses.
- `dig_en`=1100 held for 20 cycles → FSM stays in SCAN, no capture; then 1101 with `seg`=30 held → `bcd[7:4]`=1.
- Pattern 77, stable:
  - Without `SEG_HEX_EN`: one `pat_err` pulse, nibble unchanged.
  - With `SEG_HEX_EN`: nibble = A, no error.
- Assert `rst_n` low at `cnt`=5 during SETTLE → all outputs 0 asynchronously; after release, a capture occurs only after a full `STABLE_CYC+3` edges.
